fm_test_gen: RTL and testbench

- Parametrised FM stimulus generator and response monitor for the FM receiver bench.
- Supersedes the fixed-waveform input generator with a programmable carrier, deviation and modulation shape.
- Adds a windowed peak-to-peak monitor on the demodulator output, so benches check demod amplitude without waveform inspection.
- Sits between bench stimulus control and the fm demodulator (fmin/dmout).

---
 rtl/fm_test_pkg.sv | 49 ++++
 rtl/fm_test_gen_if.sv | 34 +++
 rtl/fm_pp_monitor.sv | 91 +++++++++
 rtl/fm_test_gen.sv | 101 ++++++++++
 tb/tb_fm_test_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fm_test_pkg.sv
// Shared types and helpers for the FM stimulus generator and its response monitor.
// Latency: pure declarations and combinational functions, no state.
// Backpressure: none; callers decide when results are consumed.
package fm_test_pkg;

    // Modulation shapes selectable on the mode input
    typedef enum logic [1:0] {
        MODE_NONE   = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    localparam int WIN_CNT_W = 16;

    // Triangle fold of an acc_w-bit phase accumulator into a signed out_w-bit sample.
    // The out_w bits just below the accumulator MSB form t; the MSB selects the
    // rising (t-H) or falling (H-1-t) half. When the accumulator is narrower than
    // out_w+1 bits, t is padded with zeros at the bottom so the fold still spans
    // the full output range.
    function automatic logic signed [31:0] tri_fold(input logic [31:0] acc,
                                                    input int          acc_w,
                                                    input int          out_w);
        logic [31:0] msb_sh;
        logic [31:0] t;
        logic [31:0] mask;
        logic [31:0] half;
        msb_sh = acc >> (acc_w - 1);
        if (acc_w - 1 >= out_w) begin
            t = acc >> (acc_w - 1 - out_w);
        end else begin
            t = acc << (out_w - acc_w + 1);
        end
        mask = (32'd1 << out_w) - 32'd1;
        t    = t & mask;
        half = 32'd1 << (out_w - 1);
        if (msb_sh[0]) begin
            tri_fold = signed'(half - 32'd1 - t);
        end else begin
            tri_fold = signed'(t - half);
        end
    endfunction

    // Window counter increment that sticks at all-ones
    function automatic logic [WIN_CNT_W-1:0] sat_inc(input logic [WIN_CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fm_test_gen_if.sv
// Bench-facing bundle of the FM generator: stimulus controls, FM samples, demod monitor.
// Latency: wiring only.
// Backpressure: none; every signal is sampled or driven each cycle.
interface fm_test_gen_if #(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 12,
    parameter int PHASE_W = 16,
    parameter int MOD_W   = 10
);
    logic                      enable;
    logic                      restart;
    logic [1:0]                mode;
    logic [PHASE_W-1:0]        carrier_inc;
    logic [MOD_W-1:0]          mod_inc;
    logic [2:0]                dev_shift;
    logic signed [DATA_W-1:0]  fm_out;
    logic signed [DATA_W-1:0]  fm_sq_out;
    logic signed [OUT_W-1:0]   dm_in;
    logic [OUT_W:0]            pp_out;
    logic                      pp_valid;
    logic [15:0]               win_count;

    // Stimulus side (bench control)
    modport master (
        output enable, restart, mode, carrier_inc, mod_inc, dev_shift, dm_in,
        input  fm_out, fm_sq_out, pp_out, pp_valid, win_count
    );

    // Generator side
    modport slave (
        input  enable, restart, mode, carrier_inc, mod_inc, dev_shift, dm_in,
        output fm_out, fm_sq_out, pp_out, pp_valid, win_count
    );
endinterface

// File: rtl/fm_pp_monitor.sv
// Windowed peak-to-peak tracker on the demodulator output, reported once per window.
// Latency: pp_out/pp_valid/win_count register one cycle after the wrap cycle's sample.
// Backpressure: none; holds all state while en is low, clr overrides en.
module fm_pp_monitor
    import fm_test_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    wrap,
    input  logic signed [OUT_W-1:0] dm_in,
    output logic [OUT_W:0]          pp_out,
    output logic                    pp_valid,
    output logic [WIN_CNT_W-1:0]    win_count
);

    logic signed [OUT_W-1:0] min_q, min_d, max_q, max_d;
    logic                    empty_q, empty_d;
    logic [OUT_W:0]          pp_q, pp_d;
    logic                    pp_valid_q, pp_valid_d;
    logic [WIN_CNT_W-1:0]    win_q, win_d;
    logic signed [OUT_W-1:0] cur_min, cur_max;
    logic [OUT_W:0]          diff;

    // Fold the current sample into min/max and close the window on wrap
    always_comb begin
        cur_min = min_q;
        cur_max = max_q;
        if (empty_q) begin
            cur_min = dm_in;
            cur_max = dm_in;
        end else begin
            if (dm_in < min_q) cur_min = dm_in;
            if (dm_in > max_q) cur_max = dm_in;
        end
        // One extra bit makes max-min non-negative for any pair of samples
        diff = {cur_max[OUT_W-1], cur_max} - {cur_min[OUT_W-1], cur_min};

        min_d      = min_q;
        max_d      = max_q;
        empty_d    = empty_q;
        pp_d       = pp_q;
        pp_valid_d = 1'b0;
        win_d      = win_q;
        if (clr) begin
            min_d   = '0;
            max_d   = '0;
            empty_d = 1'b1;
            pp_d    = '0;
            win_d   = '0;
        end else if (en) begin
            if (wrap) begin
                pp_d       = diff;
                pp_valid_d = 1'b1;
                win_d      = sat_inc(win_q);
                empty_d    = 1'b1;
            end else begin
                min_d   = cur_min;
                max_d   = cur_max;
                empty_d = 1'b0;
            end
        end
    end

    // Monitor state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_q      <= '0;
            max_q      <= '0;
            empty_q    <= 1'b1;
            pp_q       <= '0;
            pp_valid_q <= 1'b0;
            win_q      <= '0;
        end else begin
            min_q      <= min_d;
            max_q      <= max_d;
            empty_q    <= empty_d;
            pp_q       <= pp_d;
            pp_valid_q <= pp_valid_d;
            win_q      <= win_d;
        end
    end

    assign pp_out    = pp_q;
    assign pp_valid  = pp_valid_q;
    assign win_count = win_q;

endmodule

// File: rtl/fm_test_gen.sv
// Programmable FM carrier generator (triangle and square) with demod peak-to-peak monitor.
// Latency: FM samples reflect the phase after each enabled update, one register stage.
// Backpressure: none; enable low freezes everything, restart clears with priority.
module fm_test_gen
    import fm_test_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 12,
    parameter int PHASE_W = 16,
    parameter int MOD_W   = 10
) (
    input  logic         clock,
    input  logic         reset,
    fm_test_gen_if.slave bus
);

    localparam logic signed [MOD_W-1:0]  M_POS  = MOD_W'((1 << (MOD_W - 1)) - 1);
    localparam logic signed [MOD_W-1:0]  M_NEG  = -M_POS;
    localparam logic [MOD_W-1:0]         M_HALF = MOD_W'(1 << (MOD_W - 1));
    localparam logic signed [DATA_W-1:0] SQ_POS = DATA_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] SQ_NEG = -SQ_POS;

    logic [MOD_W-1:0]          mphase_q, mphase_d;
    logic [PHASE_W-1:0]        cphase_q, cphase_d;
    logic signed [DATA_W-1:0]  fm_out_q, fm_out_d;
    logic signed [DATA_W-1:0]  fm_sq_q, fm_sq_d;

    logic signed [MOD_W-1:0]   mod_val;
    logic signed [PHASE_W-1:0] dev_val;
    logic [PHASE_W-1:0]        car_step;
    logic [MOD_W:0]            msum;
    logic                      wrap;

    // Modulation value from the current modulation phase, scaled into a carrier step
    always_comb begin
        mod_val = '0;
        case (bus.mode)
            MODE_NONE:   mod_val = '0;
            MODE_TRI:    mod_val = MOD_W'(tri_fold(32'(mphase_q), MOD_W, MOD_W));
            MODE_SQUARE: mod_val = mphase_q[MOD_W-1] ? M_NEG : M_POS;
            MODE_SAW:    mod_val = signed'(mphase_q - M_HALF);
            default:     mod_val = '0;
        endcase
        dev_val  = PHASE_W'(mod_val);
        car_step = bus.carrier_inc + unsigned'(dev_val <<< bus.dev_shift);
    end

    // Accumulator advance and sample shaping; the carry out of the modulation add closes a window
    always_comb begin
        msum     = {1'b0, mphase_q} + {1'b0, bus.mod_inc};
        wrap     = bus.enable && !bus.restart && msum[MOD_W];
        mphase_d = mphase_q;
        cphase_d = cphase_q;
        fm_out_d = fm_out_q;
        fm_sq_d  = fm_sq_q;
        if (bus.restart) begin
            mphase_d = '0;
            cphase_d = '0;
            fm_out_d = '0;
            fm_sq_d  = '0;
        end else if (bus.enable) begin
            mphase_d = msum[MOD_W-1:0];
            cphase_d = cphase_q + car_step;
            fm_out_d = DATA_W'(tri_fold(32'(cphase_d), PHASE_W, DATA_W));
            fm_sq_d  = cphase_d[PHASE_W-1] ? SQ_NEG : SQ_POS;
        end
    end

    // Accumulator and output sample registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mphase_q <= '0;
            cphase_q <= '0;
            fm_out_q <= '0;
            fm_sq_q  <= '0;
        end else begin
            mphase_q <= mphase_d;
            cphase_q <= cphase_d;
            fm_out_q <= fm_out_d;
            fm_sq_q  <= fm_sq_d;
        end
    end

    assign bus.fm_out    = fm_out_q;
    assign bus.fm_sq_out = fm_sq_q;

    fm_pp_monitor #(
        .OUT_W(OUT_W)
    ) u_pp_monitor (
        .clock     (clock),
        .reset     (reset),
        .clr       (bus.restart),
        .en        (bus.enable),
        .wrap      (wrap),
        .dm_in     (bus.dm_in),
        .pp_out    (bus.pp_out),
        .pp_valid  (bus.pp_valid),
        .win_count (bus.win_count)
    );

endmodule

// File: tb/tb_fm_test_gen.sv
// Directed bench for fm_test_gen: carrier, FSK, windowing, peak-to-peak, hold, restart, reset.
// Latency: outputs are sampled on the falling edge after each rising edge.
// Backpressure: not applicable; inputs change only on the falling edge.
module tb_fm_test_gen;
    import fm_test_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    fm_test_gen_if #(.DATA_W(8), .OUT_W(12), .PHASE_W(16), .MOD_W(10)) bus ();

    fm_test_gen #(.DATA_W(8), .OUT_W(12), .PHASE_W(16), .MOD_W(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int pulses;
    int fm_tab [16] = '{-96, -64, -32, 0, 32, 64, 96, 127, 95, 63, 31, -1, -33, -65, -97, -128};

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.restart     = 1'b0;
        bus.mode        = 2'd0;
        bus.carrier_inc = '0;
        bus.mod_inc     = '0;
        bus.dev_shift   = '0;
        bus.dm_in       = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        check_val("reset_fm",    int'(bus.fm_out),    0);
        check_val("reset_sq",    int'(bus.fm_sq_out), 0);
        check_val("reset_pp",    int'(bus.pp_out),    0);
        check_val("reset_valid", int'(bus.pp_valid),  0);
        check_val("reset_win",   int'(bus.win_count), 0);

        // Carrier only, no modulation and no window wrap
        bus.carrier_inc = 16'h1000;
        bus.enable      = 1'b1;
        pulses = 0;
        for (int k = 0; k < 32; k++) begin
            tick(1);
            check_val("carrier_fm", int'(bus.fm_out), fm_tab[k % 16]);
            check_val("carrier_sq", int'(bus.fm_sq_out),
                      ((k % 16) < 7 || (k % 16) == 15) ? 127 : -127);
            pulses += int'(bus.pp_valid);
        end
        check_val("no_wrap_valid", pulses, 0);

        // Square FSK plus window cadence
        bus.mode      = 2'd2;
        bus.dev_shift = 3'd2;
        bus.mod_inc   = 10'd4;
        bus.restart   = 1'b1;
        tick(1);
        bus.restart   = 1'b0;
        check_val("fsk_restart_fm", int'(bus.fm_out),    0);
        check_val("fsk_restart_sq", int'(bus.fm_sq_out), 0);
        pulses = 0;
        for (int k = 1; k <= 1024; k++) begin
            tick(1);
            pulses += int'(bus.pp_valid);
            case (k)
                1: check_val("fsk_first", int'(bus.fm_out), -81);
                128: begin
                    check_val("fsk_hi_end_fm", int'(bus.fm_out), -125);
                    check_val("fsk_hi_end_sq", int'(bus.fm_sq_out), -127);
                end
                129: begin
                    check_val("fsk_lo_start_fm", int'(bus.fm_out), -116);
                    check_val("fsk_lo_start_sq", int'(bus.fm_sq_out), 127);
                end
                255: check_val("win_pre_valid", int'(bus.pp_valid), 0);
                256: begin
                    check_val("win_valid", int'(bus.pp_valid), 1);
                    check_val("win_count1", int'(bus.win_count), 1);
                    check_val("fsk_period_fm", int'(bus.fm_out), -128);
                end
                257: begin
                    check_val("win_post_valid", int'(bus.pp_valid), 0);
                    check_val("fsk_hi_again", int'(bus.fm_out), -81);
                end
                default: ;
            endcase
        end
        check_val("win_pulses", pulses, 4);
        check_val("win_count4", int'(bus.win_count), 4);

        // Ramp -100..+155 across one window, then a constant window
        for (int k = 1; k <= 256; k++) begin
            bus.dm_in = 12'(-100 + k - 1);
            tick(1);
        end
        check_val("ramp_valid", int'(bus.pp_valid), 1);
        check_val("ramp_pp", int'(bus.pp_out), 255);
        check_val("ramp_win", int'(bus.win_count), 5);
        bus.dm_in = -12'sd7;
        for (int k = 1; k <= 256; k++) begin
            tick(1);
            if (k == 128) check_val("pp_held_mid", int'(bus.pp_out), 255);
        end
        check_val("const_valid", int'(bus.pp_valid), 1);
        check_val("const_pp", int'(bus.pp_out), 0);
        check_val("const_win", int'(bus.win_count), 6);

        // Enable hold mid-window delays the window by the hold length
        bus.mode      = 2'd0;
        bus.dev_shift = 3'd0;
        bus.restart   = 1'b1;
        tick(1);
        bus.restart   = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            bus.dm_in = (k == 1) ? 12'sd50 : -12'sd7;
            tick(1);
        end
        check_val("hold_pre_fm", int'(bus.fm_out), 32);
        bus.enable = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            pulses += int'(bus.pp_valid);
        end
        check_val("hold_fm", int'(bus.fm_out), 32);
        check_val("hold_sq", int'(bus.fm_sq_out), 127);
        check_val("hold_valid", pulses, 0);
        bus.enable = 1'b1;
        tick(154);
        check_val("hold_pre_wrap", int'(bus.pp_valid), 0);
        tick(1);
        check_val("hold_wrap_valid", int'(bus.pp_valid), 1);
        check_val("hold_wrap_pp", int'(bus.pp_out), 57);
        check_val("hold_wrap_win", int'(bus.win_count), 1);
        check_val("hold_wrap_fm", int'(bus.fm_out), -128);

        // Asynchronous reset between edges
        tick(50);
        check_val("pre_arst_fm", int'(bus.fm_out), -64);
        #2 reset = 1'b1;
        #1;
        check_val("arst_fm",    int'(bus.fm_out),    0);
        check_val("arst_sq",    int'(bus.fm_sq_out), 0);
        check_val("arst_pp",    int'(bus.pp_out),    0);
        check_val("arst_valid", int'(bus.pp_valid),  0);
        check_val("arst_win",   int'(bus.win_count), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            bus.dm_in = (k == 1) ? 12'sd50 : -12'sd7;
            tick(1);
            if (k == 255) check_val("arst_pre_wrap", int'(bus.pp_valid), 0);
        end
        check_val("arst_wrap_valid", int'(bus.pp_valid), 1);
        check_val("arst_wrap_pp", int'(bus.pp_out), 57);
        check_val("arst_wrap_win", int'(bus.win_count), 1);

        // Restart together with enable wins and skips accumulation
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        check_val("restart_fm",  int'(bus.fm_out),    0);
        check_val("restart_sq",  int'(bus.fm_sq_out), 0);
        check_val("restart_win", int'(bus.win_count), 0);
        check_val("restart_pp",  int'(bus.pp_out),    0);
        tick(1);
        check_val("restart_next_fm", int'(bus.fm_out), -96);

        // Triangle and sawtooth modulation shapes
        bus.mode    = 2'd1;
        bus.mod_inc = 10'd256;
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        tick(1);
        check_val("tri_1", int'(bus.fm_out), -100);
        tick(1);
        check_val("tri_2", int'(bus.fm_out), -68);
        bus.mode    = 2'd3;
        bus.restart = 1'b1;
        tick(1);
        bus.restart = 1'b0;
        tick(1);
        check_val("saw_1", int'(bus.fm_out), -100);
        tick(1);
        check_val("saw_2", int'(bus.fm_out), -70);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
